// File: rtl/instr_mem_writer.sv
// Serialises accepted Y86 instructions into byte writes to instruction memory.
// Build option: define IMEM_WR_BOUNDCHK_EN to reject instructions ending past address 1000.
module instr_mem_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_pc,
    input  logic [10:0] pc_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valC,
    output logic        wr_en,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [10:0] next_addr,
    output logic        done,
    output logic        err
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t      state, state_nx;
    logic [10:0] ptr;
    logic [3:0]  cnt;
    logic [3:0]  len;
    logic [3:0]  icode_r, ifun_r, ra_r, rb_r;
    logic [63:0] valc_r;
    logic        err_r;

    logic        accept;
    logic        reject;
    logic        out_of_range;
    logic [3:0]  len_in;
    logic        has_reg;
    logic [2:0]  valc_idx;
    logic [7:0]  reg_byte;
    logic [7:0]  emit_byte;

    function automatic logic [3:0] instr_len(input logic [3:0] ic);
        case (ic)
            4'd0, 4'd1, 4'd9:          instr_len = 4'd1;
            4'd2, 4'd6, 4'd10, 4'd11:  instr_len = 4'd2;
            4'd7, 4'd8:                instr_len = 4'd9;
            4'd3, 4'd4, 4'd5:          instr_len = 4'd10;
            default:                   instr_len = 4'd0;
        endcase
    endfunction

    assign in_ready  = (state == IDLE) && !load_pc;
    assign accept    = in_valid && in_ready;
    assign len_in    = instr_len(icode);
    assign next_addr = ptr;
    assign err       = err_r;

`ifdef IMEM_WR_BOUNDCHK_EN
    logic [11:0] last_addr;
    assign last_addr    = {1'b0, ptr} + {8'd0, len_in} - 12'd1;
    assign out_of_range = last_addr > 12'd1000;
`else
    assign out_of_range = 1'b0;
`endif

    assign reject = (icode > 4'd11) || out_of_range;

    // valC follows the register byte when present, otherwise directly after byte0
    always_comb begin
        has_reg  = (icode_r inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd10, 4'd11});
        valc_idx = cnt[2:0] - (has_reg ? 3'd2 : 3'd1);
        case (icode_r)
            4'd3:         reg_byte = {4'hF, rb_r};
            4'd10, 4'd11: reg_byte = {ra_r, 4'hF};
            default:      reg_byte = {ra_r, rb_r};
        endcase
        if (cnt == 4'd0)
            emit_byte = {icode_r, ifun_r};
        else if (has_reg && cnt == 4'd1)
            emit_byte = reg_byte;
        else
            emit_byte = valc_r[{valc_idx, 3'b000} +: 8];
    end

    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !reject)
                    state_nx = EMIT;
            end
            EMIT: begin
                wr_en   = 1'b1;
                wr_addr = ptr;
                wr_data = emit_byte;
                if (cnt == len - 4'd1) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            cnt   <= '0;
            err_r <= 1'b0;
        end else begin
            state <= state_nx;
            err_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_pc) begin
                        ptr <= pc_in;
                    end else if (in_valid) begin
                        if (reject) begin
                            err_r <= 1'b1;
                        end else begin
                            icode_r <= icode;
                            ifun_r  <= ifun;
                            ra_r    <= rA;
                            rb_r    <= rB;
                            valc_r  <= valC;
                            len     <= len_in;
                            cnt     <= '0;
                        end
                    end
                end
                EMIT: begin
                    ptr <= ptr + 11'd1;
                    cnt <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
